mem_req_ctrl: RTL
=================

MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 Parameter ADDR_W, default 11, word address width.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 resetn  input  1  reset is synchronous and active-low.
REQ-005 if_req  input  1  fetch read request; always accepted, no ready.
REQ-006 if_adrs  input  ADDR_W  fetch word address.
REQ-007 if_rvalid  output  1  fetch data valid.
REQ-008 if_rdata  output  DATA_W  fetch read data.
REQ-009 ls_req  input  1  load/store request valid.
REQ-010 ls_we  input  1  1 = store, 0 = load.
REQ-011 ls_adrs  input  ADDR_W  load/store word address.
REQ-012 ls_wdata  input  DATA_W  store data.
REQ-013 ls_ready  output  1  load/store request accepted when ls_req & ls_ready.
REQ-014 ls_rvalid  output  1  load data valid, held until acknowledged.
REQ-015 ls_rdata  output  DATA_W  load data.
REQ-016 ls_rack  input  1  load data consumed.
REQ-017 Memory-side ports: w_adrs, r_adrs1, r_adrs2 (outputs, ADDR_W); data_in (output, DATA_W); w_en, r_en1, r_en2 (outputs, 1); data_out1, data_out2 (inputs, DATA_W, one-cycle registered read data).

Function
REQ-018 Port mapping: fetch uses read port 1 (r_en1, r_adrs1, data_out1); loads use read port 2; stores use the write port.
REQ-019 r_en1 = if_req & resetn, r_adrs1 = if_adrs, combinational.
REQ-020 if_rvalid SHALL rise exactly one cycle after a cycle with if_req = 1 and SHALL be low otherwise; if_rdata = data_out1 in that cycle.
REQ-021 Write-read hazard: if a store is issued (w_en = 1) in the same cycle as if_req with w_adrs == if_adrs, if_rdata in the following cycle SHALL equal the stored data, not data_out1.
REQ-022 FSM states: IDLE, RESP.
REQ-023 ls_ready = 1 in IDLE; ls_ready = ls_rack in RESP; ls_ready = 0 while resetn = 0.
REQ-024 An accepted store SHALL drive w_en = 1, w_adrs = ls_adrs and data_in = ls_wdata in the acceptance cycle (combinational); the FSM state is unchanged by a store.
REQ-025 An accepted load SHALL drive r_en2 = 1 and r_adrs2 = ls_adrs in the acceptance cycle, then enter RESP.
REQ-026 RESP, first cycle: capture data_out2 into the response register; ls_rvalid = 1; ls_rdata = data_out2.
REQ-027 RESP, later cycles: ls_rdata = the held register value, stable until ls_rack.
REQ-028 RESP with ls_rack = 1 and no new load accepted: next state IDLE, ls_rvalid low the next cycle.
REQ-029 RESP with ls_rack = 1 and a new load accepted: remain in RESP; the new data appears with ls_rvalid = 1 in the next cycle (back-to-back, one load per cycle).
REQ-030 RESP with ls_rack = 1 and a store accepted: the store is performed and the state becomes IDLE.
REQ-031 A load accepted the cycle after a store to the same address SHALL return the stored data (memory write-then-read ordering; no forwarding needed).
REQ-032 w_en, r_en1 and r_en2 SHALL never be asserted while resetn = 0.

Reset
REQ-033 While resetn = 0 at a rising edge: state becomes IDLE, response register cleared, if_rvalid = 0, ls_rvalid = 0, ls_rdata = 0, if_rdata = 0.
REQ-034 Reset asserted in RESP SHALL drop the pending load without a response; ls_ready = 1 in the first cycle after resetn returns high.

Verification
REQ-035 Reset, then store 0xDEADBEEF to address 5, then load address 5 the next cycle -> ls_rvalid = 1 with ls_rdata = 0xDEADBEEF two cycles after the store.
REQ-036 Store 0x12345678 to address 0x7FF and if_req to address 0x7FF in the same cycle -> next cycle if_rvalid = 1, if_rdata = 0x12345678.
REQ-037 Load address 3 (contents 0xA5), ls_rack held low for 4 cycles -> ls_rvalid and ls_rdata = 0xA5 stable for all 4 cycles; ls_ready = 0 throughout.
REQ-038 Back-to-back loads to addresses 1, 2, 3 with ls_rack = 1 every cycle -> ls_rvalid high for 3 consecutive cycles with data in address order.
REQ-039 Load accepted, then resetn = 0 for one cycle during RESP -> ls_rvalid = 0, no w_en/r_en pulses during reset, ls_ready = 1 in the first cycle after reset.
REQ-040 Continuous if_req on addresses 0..7 concurrent with loads/stores -> each fetch returns in exactly one cycle, with no interference between the port 1 and port 2 data.

Source files
------------

// File: rtl/mem_req_ctrl.sv
// Purpose: arbitrates a fetch read stream and a load/store stream onto a 1W/2R synchronous memory.
// Latency: fetch data one cycle after if_req; load data one cycle after acceptance; stores are performed in the acceptance cycle.
// Backpressure: fetch is never stalled; load/store stalls (ls_ready=0) while a load response waits for ls_rack.
module mem_req_ctrl #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    // fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_adrs,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    // load/store port
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_adrs,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_ready,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    input  logic              ls_rack,
    // memory side
    output logic [ADDR_W-1:0] w_adrs,
    output logic [DATA_W-1:0] data_in,
    output logic              w_en,
    output logic [ADDR_W-1:0] r_adrs1,
    output logic              r_en1,
    input  logic [DATA_W-1:0] data_out1,
    output logic [ADDR_W-1:0] r_adrs2,
    output logic              r_en2,
    input  logic [DATA_W-1:0] data_out2
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              first_q, first_d;     // first cycle of a load response: data comes straight from memory
    logic [DATA_W-1:0] resp_q, resp_d;       // held load data while waiting for ls_rack
    logic              if_vld_q, if_vld_d;
    logic              fwd_q, fwd_d;         // fetch collided with a same-address store last cycle
    logic [DATA_W-1:0] fwd_dat_q, fwd_dat_d;

    logic ls_acc;

    // Request-side handshake and memory port drive; all gated by reset so nothing reaches memory in reset.
    always_comb begin
        ls_ready = resetn & ((state_q == IDLE) | ls_rack);
        ls_acc   = ls_req & ls_ready;

        w_en     = ls_acc & ls_we;
        w_adrs   = ls_adrs;
        data_in  = ls_wdata;

        r_en2    = ls_acc & ~ls_we;
        r_adrs2  = ls_adrs;

        r_en1    = if_req & resetn;
        r_adrs1  = if_adrs;
    end

    // Next-state logic for the load response FSM and the fetch pipeline stage.
    always_comb begin
        state_d   = state_q;
        first_d   = 1'b0;
        resp_d    = resp_q;
        if_vld_d  = r_en1;
        fwd_d     = r_en1 & w_en & (w_adrs == if_adrs);
        fwd_dat_d = fwd_d ? ls_wdata : fwd_dat_q;

        // Memory read data is only valid in the first response cycle, so capture it then.
        if ((state_q == RESP) && first_q) begin
            resp_d = data_out2;
        end

        case (state_q)
            IDLE: begin
                if (r_en2) begin
                    state_d = RESP;
                    first_d = 1'b1;
                end
            end
            RESP: begin
                if (ls_rack) begin
                    if (r_en2) begin
                        state_d = RESP;
                        first_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Response outputs; forced low during reset so a dropped load never shows a response.
    always_comb begin
        ls_rvalid = resetn & (state_q == RESP);
        if (!ls_rvalid) begin
            ls_rdata = '0;
        end else if (first_q) begin
            ls_rdata = data_out2;
        end else begin
            ls_rdata = resp_q;
        end

        if_rvalid = resetn & if_vld_q;
        if (!if_rvalid) begin
            if_rdata = '0;
        end else if (fwd_q) begin
            if_rdata = fwd_dat_q;
        end else begin
            if_rdata = data_out1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            first_q   <= 1'b0;
            resp_q    <= '0;
            if_vld_q  <= 1'b0;
            fwd_q     <= 1'b0;
            fwd_dat_q <= '0;
        end else begin
            state_q   <= state_d;
            first_q   <= first_d;
            resp_q    <= resp_d;
            if_vld_q  <= if_vld_d;
            fwd_q     <= fwd_d;
            fwd_dat_q <= fwd_dat_d;
        end
    end

endmodule
